// File: rtl/trace_capture.sv
// ----------------------------------------------------------------------------
// trace_capture
//
// Instruction-trace capture buffer. A session is started with arm_i. Every
// unstalled cycle in ARMED/POST writes one entry {cyc, pc, branch, wb_en,
// dest, data} into a DEPTH-entry ring. A PC match (or force_trig_i) moves the
// block to POST, which collects DEPTH-PRE_TRIG-1 further entries so the ring
// ends up holding up to PRE_TRIG pre-trigger entries, the trigger entry and
// the post-trigger entries. The frozen ring is then streamed out oldest-first
// over a valid/ready interface.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   arm_i             start a capture session (IDLE or DONE only)
//   abort_i           abandon session, back to IDLE
//   force_trig_i      unconditional trigger (ignored on stalled cycles)
//   trig_en_i         enable PC-match trigger
//   trig_pc_i         trigger PC
//   pc_i              PC of the retiring instruction
//   stall_i           pipeline stall, cycle not recorded
//   branch_i          branch taken
//   wb_en_i           write-back enable
//   dest_reg_addr_i   write-back register
//   wb_data_i         write-back data
//   rd_ready_i        readout sink ready
//   rd_valid_o        readout entry valid
//   rd_data_o         readout entry {cyc, pc, branch, wb_en, dest, data}
//   rd_last_o         final entry of the readout
//   armed_o           capturing (ARMED or POST)
//   done_o            capture complete, ring frozen
//   count_o           valid entries held in the ring
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no session; waiting for arm_i
// ARMED  | capturing pre-trigger history, watching for a trigger
// POST   | trigger seen; capturing the post-trigger window
// DONE   | ring frozen; waiting for rd_ready_i (readout) or arm_i (restart)
// READ   | streaming entries oldest-first
// ----------------------------------------------------------------------------
module trace_capture #(
   parameter int PC_W     = 16,
   parameter int DATA_W   = 32,
   parameter int RADDR_W  = 3,
   parameter int DEPTH    = 64,
   parameter int PRE_TRIG = 16,
   parameter int CYC_W    = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      arm_i,
   input  logic                                      abort_i,
   input  logic                                      force_trig_i,
   input  logic                                      trig_en_i,
   input  logic [PC_W-1:0]                           trig_pc_i,
   input  logic [PC_W-1:0]                           pc_i,
   input  logic                                      stall_i,
   input  logic                                      branch_i,
   input  logic                                      wb_en_i,
   input  logic [RADDR_W-1:0]                        dest_reg_addr_i,
   input  logic [DATA_W-1:0]                         wb_data_i,
   input  logic                                      rd_ready_i,
   output logic                                      rd_valid_o,
   output logic [CYC_W+PC_W+2+RADDR_W+DATA_W-1:0]    rd_data_o,
   output logic                                      rd_last_o,
   output logic                                      armed_o,
   output logic                                      done_o,
   output logic [$clog2(DEPTH):0]                    count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = CYC_W + PC_W + 2 + RADDR_W + DATA_W;

   localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
   localparam logic [CW-1:0] POST_INIT_C = CW'(DEPTH - PRE_TRIG - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARMED = 3'd1;
   localparam logic [2:0] S_POST  = 3'd2;
   localparam logic [2:0] S_DONE  = 3'd3;
   localparam logic [2:0] S_READ  = 3'd4;

   logic [2:0]       r_state;
   logic [CYC_W-1:0] r_cyc;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    r_post_left;
   logic [CW-1:0]    r_rd_num;     // 1-based index of the entry on rd_data_o
   logic             r_rd_valid;
   logic [EW-1:0]    r_rd_data;
   logic [EW-1:0]    r_ram [DEPTH];

   logic             w_capturing;
   logic             w_cap;
   logic             w_pc_hit;
   logic             w_trig;
   logic             w_arm;
   logic             w_rd_last;
   logic             w_xfer;
   logic             w_fetch;
   logic [EW-1:0]    w_entry;

   assign w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
   // A stalled cycle records nothing, so it can neither write nor trigger.
   assign w_cap       = w_capturing && !stall_i && !abort_i;
   assign w_pc_hit    = trig_en_i && (pc_i == trig_pc_i);
   assign w_trig      = (r_state == S_ARMED) && w_cap && (w_pc_hit || force_trig_i);
   assign w_arm       = !abort_i && arm_i && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_entry     = {r_cyc, pc_i, branch_i, wb_en_i, dest_reg_addr_i, wb_data_i};

   assign w_rd_last   = r_rd_valid && (r_rd_num == r_count);
   assign w_xfer      = (r_state == S_READ) && r_rd_valid && rd_ready_i && !abort_i;
   // Load the output register on READ entry (nothing presented yet) and after
   // each transfer that still has entries behind it.
   assign w_fetch     = (r_state == S_READ) && !abort_i &&
                        (!r_rd_valid || (rd_ready_i && !w_rd_last));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cyc       <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_post_left <= '0;
         r_rd_num    <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_cyc <= w_arm ? '0 : r_cyc + CYC_W'(1);

         if (abort_i) begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
         end else begin
            if (w_cap) begin
               r_wr_ptr <= r_wr_ptr + AW'(1);
               if (r_count != DEPTH_C) begin
                  r_count <= r_count + CW'(1);
               end
            end

            case (r_state)
               S_IDLE: begin
                  if (arm_i) begin
                     r_count     <= '0;
                     r_wr_ptr    <= '0;
                     r_post_left <= '0;
                     r_state     <= S_ARMED;
                  end
               end

               S_ARMED: begin
                  if (w_trig) begin
                     r_post_left <= POST_INIT_C;
                     // With no post-trigger window left the trigger entry is the last one.
                     r_state     <= (POST_INIT_C == '0) ? S_DONE : S_POST;
                  end
               end

               S_POST: begin
                  if (w_cap) begin
                     r_post_left <= r_post_left - CW'(1);
                     if (r_post_left == CW'(1)) begin
                        r_state <= S_DONE;
                     end
                  end
               end

               S_DONE: begin
                  if (arm_i) begin
                     r_count     <= '0;
                     r_wr_ptr    <= '0;
                     r_post_left <= '0;
                     r_state     <= S_ARMED;
                  end else if (rd_ready_i) begin
                     // Oldest entry sits count slots behind the write pointer;
                     // a full ring gives back wr_ptr itself.
                     r_rd_ptr   <= r_wr_ptr - r_count[AW-1:0];
                     r_rd_num   <= '0;
                     r_rd_valid <= 1'b0;
                     r_state    <= S_READ;
                  end
               end

               S_READ: begin
                  if (w_xfer && w_rd_last) begin
                     r_rd_valid <= 1'b0;
                     r_state    <= S_IDLE;
                  end else if (w_fetch) begin
                     r_rd_valid <= 1'b1;
                     r_rd_ptr   <= r_rd_ptr + AW'(1);
                     r_rd_num   <= r_rd_num + CW'(1);
                  end
               end

               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Ring storage: one write port, synchronous read into the output register.
   always_ff @(posedge clk) begin
      if (!rst && w_cap) begin
         r_ram[r_wr_ptr] <= w_entry;
      end
      if (!rst && w_fetch) begin
         r_rd_data <= r_ram[r_rd_ptr];
      end
   end

   assign rd_valid_o = r_rd_valid;
   assign rd_data_o  = r_rd_data;
   assign rd_last_o  = w_rd_last;
   assign armed_o    = w_capturing;
   assign done_o     = (r_state == S_DONE);
   assign count_o    = r_count;

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

   localparam int PC_W     = 16;
   localparam int DATA_W   = 32;
   localparam int RADDR_W  = 3;
   localparam int DEPTH    = 8;
   localparam int PRE_TRIG = 3;
   localparam int CYC_W    = 16;
   localparam int EW       = CYC_W + PC_W + 2 + RADDR_W + DATA_W;
   localparam int CW       = $clog2(DEPTH) + 1;
   localparam int NSTIM    = 64;

   logic                 clk;
   logic                 rst;
   logic                 arm_i;
   logic                 abort_i;
   logic                 force_trig_i;
   logic                 trig_en_i;
   logic [PC_W-1:0]      trig_pc_i;
   logic [PC_W-1:0]      pc_i;
   logic                 stall_i;
   logic                 branch_i;
   logic                 wb_en_i;
   logic [RADDR_W-1:0]   dest_reg_addr_i;
   logic [DATA_W-1:0]    wb_data_i;
   logic                 rd_ready_i;
   logic                 rd_valid_o;
   logic [EW-1:0]        rd_data_o;
   logic                 rd_last_o;
   logic                 armed_o;
   logic                 done_o;
   logic [CW-1:0]        count_o;

   trace_capture #(
      .PC_W     (PC_W),
      .DATA_W   (DATA_W),
      .RADDR_W  (RADDR_W),
      .DEPTH    (DEPTH),
      .PRE_TRIG (PRE_TRIG),
      .CYC_W    (CYC_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .arm_i           (arm_i),
      .abort_i         (abort_i),
      .force_trig_i    (force_trig_i),
      .trig_en_i       (trig_en_i),
      .trig_pc_i       (trig_pc_i),
      .pc_i            (pc_i),
      .stall_i         (stall_i),
      .branch_i        (branch_i),
      .wb_en_i         (wb_en_i),
      .dest_reg_addr_i (dest_reg_addr_i),
      .wb_data_i       (wb_data_i),
      .rd_ready_i      (rd_ready_i),
      .rd_valid_o      (rd_valid_o),
      .rd_data_o       (rd_data_o),
      .rd_last_o       (rd_last_o),
      .armed_o         (armed_o),
      .done_o          (done_o),
      .count_o         (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Per-cycle stimulus for one capture session (cycle k = k-th cycle after arm).
   logic [PC_W-1:0]    s_pc    [NSTIM];
   bit                 s_stall [NSTIM];
   bit                 s_force [NSTIM];
   bit                 s_br    [NSTIM];
   bit                 s_wb    [NSTIM];
   logic [RADDR_W-1:0] s_dest  [NSTIM];
   logic [DATA_W-1:0]  s_data  [NSTIM];
   int                 s_len;

   // Expected ring contents, oldest first.
   logic [EW-1:0]      exp_q [$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_linear(input int len);
      for (int k = 0; k < NSTIM; k++) begin
         s_pc[k]    = PC_W'(k);
         s_stall[k] = 1'b0;
         s_force[k] = 1'b0;
         s_br[k]    = 1'($urandom);
         s_wb[k]    = 1'($urandom);
         s_dest[k]  = RADDR_W'($urandom);
         s_data[k]  = $urandom;
      end
      s_len = len;
   endtask

   task automatic do_arm();
      arm_i = 1'b1;
      @(negedge clk);
      arm_i = 1'b0;
      chk("arm_armed", 128'(armed_o), 128'(1));
      chk("arm_done", 128'(done_o), 128'(0));
      chk("arm_count", 128'(count_o), 128'(0));
   endtask

   // Drives the session and builds the expected ring: the trigger is the first
   // unstalled cycle that matches; the window closes DEPTH-PRE_TRIG-1 captures
   // later (or stop_post captures later when stop_post >= 0). Retained history
   // is the last PRE_TRIG captures before the trigger plus everything after.
   task automatic run_capture(input logic [PC_W-1:0] tpc, input bit ten,
                              input int stop_post, output bit reached);
      logic [EW-1:0] caps [$];
      int ti;
      int lo;
      bit fin;
      caps.delete();
      ti  = -1;
      fin = 1'b0;
      trig_pc_i = tpc;
      trig_en_i = ten;
      for (int k = 0; k < s_len && !fin; k++) begin
         pc_i            = s_pc[k];
         stall_i         = s_stall[k];
         force_trig_i    = s_force[k];
         branch_i        = s_br[k];
         wb_en_i         = s_wb[k];
         dest_reg_addr_i = s_dest[k];
         wb_data_i       = s_data[k];
         if (!s_stall[k]) begin
            caps.push_back({CYC_W'(k), s_pc[k], s_br[k], s_wb[k], s_dest[k], s_data[k]});
            if (ti < 0 && ((ten && s_pc[k] == tpc) || s_force[k]))
               ti = caps.size() - 1;
            if (ti >= 0 && stop_post < 0 && caps.size() - 1 == ti + DEPTH - PRE_TRIG - 1)
               fin = 1'b1;
            if (ti >= 0 && stop_post >= 0 && caps.size() - 1 == ti + stop_post)
               fin = 1'b1;
         end
         @(negedge clk);
      end
      stall_i      = 1'b1;
      force_trig_i = 1'b0;
      trig_en_i    = 1'b0;
      exp_q.delete();
      if (ti >= 0) begin
         lo = (ti > PRE_TRIG) ? ti - PRE_TRIG : 0;
         for (int i = lo; i < caps.size(); i++) exp_q.push_back(caps[i]);
      end
      reached = fin;
   endtask

   task automatic check_done();
      chk("done_flag", 128'(done_o), 128'(1));
      chk("done_armed", 128'(armed_o), 128'(0));
      chk("done_valid", 128'(rd_valid_o), 128'(0));
      chk("done_count", 128'(count_o), 128'(exp_q.size()));
   endtask

   // Streams up to max_xfer entries; pat gives rd_ready_i per cycle once data is valid.
   task automatic read_out(input bit [3:0] pat, input int max_xfer);
      int idx;
      int n;
      bit held;
      logic [EW-1:0] hold_d;
      idx  = 0;
      n    = exp_q.size();
      held = 1'b0;
      hold_d = '0;
      rd_ready_i = 1'b1;
      @(negedge clk);
      rd_ready_i = 1'b0;
      chk("rd_first_lat", 128'(rd_valid_o), 128'(0));
      @(negedge clk);
      chk("rd_first_valid", 128'(rd_valid_o), 128'(1));
      for (int j = 0; j < 200 && idx < n && idx < max_xfer; j++) begin
         rd_ready_i = pat[j % 4];
         if (rd_valid_o) begin
            if (held) chk("rd_stable", 128'(rd_data_o), 128'(hold_d));
            if (rd_ready_i) begin
               chk("rd_data", 128'(rd_data_o), 128'(exp_q[idx]));
               chk("rd_last", 128'(rd_last_o), 128'(idx == n - 1));
               idx++;
               held = 1'b0;
            end else begin
               held   = 1'b1;
               hold_d = rd_data_o;
            end
         end
         @(negedge clk);
      end
      rd_ready_i = 1'b0;
      if (max_xfer >= n) begin
         chk("rd_all_xfers", 128'(idx), 128'(n));
         chk("rd_end_state", 128'({armed_o, done_o, rd_valid_o}), 128'(0));
         chk("rd_end_count", 128'(count_o), 128'(n));
      end
   endtask

   task automatic check_quiet(input string tag);
      chk(tag, 128'({rd_valid_o, rd_last_o, armed_o, done_o}), 128'(0));
   endtask

   initial begin
      bit ok;
      logic [PC_W-1:0] tpc;
      bit [3:0] pat;

      rst = 1'b1; arm_i = 1'b0; abort_i = 1'b0; force_trig_i = 1'b0;
      trig_en_i = 1'b0; trig_pc_i = '0; pc_i = '0; stall_i = 1'b0;
      branch_i = 1'b0; wb_en_i = 1'b0; dest_reg_addr_i = '0; wb_data_i = '0;
      rd_ready_i = 1'b0;

      // Reset
      repeat (3) @(negedge clk);
      check_quiet("rst_during_flags");
      chk("rst_during_count", 128'(count_o), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      check_quiet("rst_after_flags");
      chk("rst_after_count", 128'(count_o), 128'(0));

      // PC-match at 6: window pc 3..10
      fill_linear(13);
      do_arm();
      run_capture(16'd6, 1'b1, -1, ok);
      chk("s1_reached", 128'(ok), 128'(1));
      check_done();
      chk("s1_count", 128'(count_o), 128'(8));
      chk("s1_oldest_pc", 128'(exp_q[0][EW-CYC_W-1 -: PC_W]), 128'(3));
      read_out(4'b1111, 99);

      // Early trigger at pc 1: entries 0..5
      fill_linear(13);
      do_arm();
      run_capture(16'd1, 1'b1, -1, ok);
      chk("s2_reached", 128'(ok), 128'(1));
      check_done();
      chk("s2_count", 128'(count_o), 128'(6));
      read_out(4'b1111, 99);

      // Stalls on cycles 2,3 (force during stall ignored), force at pc 4;
      // readout with ready pattern 1,0,0,1
      fill_linear(13);
      s_stall[2] = 1'b1; s_stall[3] = 1'b1;
      s_force[3] = 1'b1; s_force[4] = 1'b1;
      do_arm();
      run_capture(16'hffff, 1'b0, -1, ok);
      chk("s3_reached", 128'(ok), 128'(1));
      check_done();
      chk("s3_count", 128'(count_o), 128'(7));
      read_out(4'b1001, 99);

      // rst mid-READ, then a normal session
      fill_linear(13);
      do_arm();
      run_capture(16'd6, 1'b1, -1, ok);
      check_done();
      read_out(4'b1111, 3);
      rst = 1'b1;
      @(negedge clk);
      check_quiet("rst_midread_flags");
      chk("rst_midread_count", 128'(count_o), 128'(0));
      rst = 1'b0;
      @(negedge clk);
      check_quiet("rst_midread_after");
      fill_linear(13);
      do_arm();
      run_capture(16'd1, 1'b1, -1, ok);
      check_done();
      read_out(4'b1111, 99);

      // abort mid-POST, then a normal session
      fill_linear(13);
      do_arm();
      run_capture(16'd6, 1'b1, 1, ok);
      chk("abort_in_post", 128'({armed_o, done_o}), 128'(2'b10));
      abort_i = 1'b1;
      arm_i   = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      arm_i   = 1'b0;
      check_quiet("abort_idle");
      fill_linear(13);
      do_arm();
      run_capture(16'd6, 1'b1, -1, ok);
      check_done();
      read_out(4'b1101, 99);

      // Randomised sessions
      for (int r = 0; r < 8; r++) begin
         fill_linear(60);
         for (int k = 0; k < 60; k++) begin
            s_pc[k]    = PC_W'($urandom_range(0, 15));
            s_stall[k] = ($urandom_range(0, 3) == 0);
            s_force[k] = ($urandom_range(0, 15) == 0);
         end
         s_stall[30] = 1'b0;
         s_force[30] = 1'b1;
         tpc = PC_W'($urandom_range(0, 15));
         pat = 4'($urandom) | 4'b0001;
         do_arm();
         run_capture(tpc, 1'($urandom), -1, ok);
         chk("rnd_reached", 128'(ok), 128'(1));
         check_done();
         read_out(pat, 99);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 The block SHALL have parameter PC_W, default 16, meaning program-counter width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning write-back data width.
REQ-003 The block SHALL have parameter RADDR_W, default 3, meaning register-address width.
REQ-004 The block SHALL have parameter DEPTH, default 64, meaning trace entries (power of 2, >=4).
REQ-005 The block SHALL have parameter PRE_TRIG, default 16, meaning pre-trigger entries retained (1..DEPTH-1).
REQ-006 The block SHALL have parameter CYC_W, default 16, meaning cycle-stamp width.
REQ-007 The block SHALL have these ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- arm_i  in  1  start capture session.
- abort_i  in  1  abandon session.
- force_trig_i  in  1  unconditional trigger.
- trig_en_i  in  1  enable PC-match trigger.
- trig_pc_i  in  PC_W  trigger PC.
- pc_i  in  PC_W  PC of the retiring instruction.
- stall_i  in  1  pipeline stall; cycle not recorded.
- branch_i  in  1  branch taken this cycle.
- wb_en_i  in  1  write-back enable.
- dest_reg_addr_i  in  RADDR_W  write-back register.
- wb_data_i  in  DATA_W  write-back data.
- rd_ready_i  in  1  readout sink ready.
- rd_valid_o  out  1  readout entry valid.
- rd_data_o  out  CYC_W+PC_W+2+RADDR_W+DATA_W  readout entry {cyc, pc, branch, wb_en, dest, data}.
- rd_last_o  out  1  final entry of the readout.
- armed_o  out  1  state is ARMED or POST.
- done_o  out  1  state is DONE.
- count_o  out  clog2(DEPTH)+1  valid entries held.

Function
REQ-008 The block SHALL have states IDLE, ARMED, POST, DONE and READ; all transitions SHALL occur on the rising edge of clk.
REQ-009 The free-running cycle counter SHALL increment every clock, including stalled cycles, wrap modulo 2^CYC_W, and clear on rst and on arm.
REQ-010 The block SHALL record a capture cycle when the state is ARMED or POST and stall_i=0: one entry is written to the ring at wr_ptr, wr_ptr is incremented modulo DEPTH, and count saturates at DEPTH.
REQ-011 In IDLE, an arm_i pulse SHALL clear count, wr_ptr and the cycle counter and move the state to ARMED; arm_i SHALL be ignored in every other state except DONE.
REQ-012 The block SHALL trigger in ARMED on a capture cycle with (trig_en_i=1 and pc_i==trig_pc_i) or force_trig_i=1.
- The triggering entry is written.
- State moves to POST.
- post_left = DEPTH-PRE_TRIG-1.
REQ-013 force_trig_i SHALL have no effect when the cycle is stalled.
REQ-014 In POST, each capture cycle SHALL decrement post_left; the capture cycle on which post_left reaches 0 is written, and the state then moves to DONE.
REQ-015 If post_left is already 0 at trigger (PRE_TRIG=DEPTH-1), the state SHALL move straight to DONE.
REQ-016 The retained history SHALL be min(pre-trigger captures, PRE_TRIG) entries followed by DEPTH-PRE_TRIG post-trigger entries, the trigger entry included; older pre-trigger entries are overwritten by ring wrap.
REQ-017 In DONE the ring SHALL freeze, and done_o=1.
REQ-018 In DONE, a single cycle with rd_ready_i=1 SHALL enter READ with rd_ptr = (wr_ptr - count) mod DEPTH.
REQ-019 In DONE, arm_i SHALL restart the session and discard the ring.
REQ-020 In READ, rd_valid_o SHALL be 1 and entries SHALL be presented oldest first.
- A transfer occurs when rd_valid_o & rd_ready_i; it advances rd_ptr.
- rd_data_o is held stable while rd_ready_i=0.
REQ-021 rd_last_o SHALL be 1 on the count-th entry; its transfer SHALL return the state to IDLE with count retained.
REQ-022 Ring memory SHALL be synchronous-read; the first rd_valid_o SHALL be asserted one cycle after entering READ.
REQ-023 abort_i SHALL return any state to IDLE next cycle with rd_valid_o=0 and ring contents unspecified; abort_i has priority over arm_i, triggers and transfers.
REQ-024 A trigger and a stall in the same cycle SHALL produce no trigger and no entry.

Reset
REQ-025 On rst, the state SHALL be IDLE and the registers SHALL clear: count=0, wr_ptr=0, rd_ptr=0, post_left=0, cycle counter 0.
REQ-026 During and after rst, the outputs SHALL be rd_valid_o=0, rd_last_o=0, armed_o=0, done_o=0 and count_o=0; ring RAM contents need not be cleared.
REQ-027 rst SHALL take priority over all other inputs, including mid-capture and mid-readout.

Verification
REQ-028 The bench SHALL cover these directed scenarios with DEPTH=8, PRE_TRIG=3:
- Reset -> state IDLE; all outputs 0.
- Arm; pc 0..12 unstalled; trig_pc=6 -> DONE after the pc=10 capture; count=8; readout pc 3..10 in order; rd_last_o with pc=10; then IDLE.
- Arm; trig_pc=1 -> entries pc 0..5; count=6; rd_last_o on pc=5.
- Arm; stall_i=1 on cycles 2 and 3; force_trig_i at pc=4 -> stalled PCs absent; cyc field gaps of 3; force_trig_i during a stall ignored.
- Readout with rd_ready_i toggled 1,0,0,1 -> rd_data_o stable while low; no entry lost or duplicated.
- rst asserted mid-READ, and abort_i mid-POST -> IDLE next cycle; rd_valid_o=0; a subsequent arm captures normally.
